// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle MIPS datapath.
// Handshaked request in, wait states, byte/half/word access, handshaked response out.
module mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  if (LATENCY < 1 || LATENCY > 15) begin : g_lat_chk
    $error("mem_responder: LATENCY out of range 1..15");
  end

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t          state_q;
  state_t          state_d;
  logic [3:0]      cnt_q;
  logic [3:0]      cnt_d;
  req_t            req_q;
  req_t            acc;
  logic            do_acc;

  logic [31:0]     mem [DEPTH_WORDS];

  logic [1:0]      lane;
  logic [AW-1:0]   idx;
  logic            oor;
  logic            fault;
  logic [3:0]      be;
  logic [31:0]     word;
  logic [31:0]     rd_sh;
  logic [31:0]     rdata_d;
  logic [31:0]     wdata_sh;

  // In IDLE the access (LATENCY=1) happens on the accept edge,
  // before the latch holds anything, so use the live request.
  always_comb begin
    acc = req_q;
    if (state_q == IDLE) begin
      acc.we    = req_we;
      acc.size  = req_size;
      acc.addr  = req_addr;
      acc.wdata = req_wdata;
    end
  end

  assign lane = acc.addr[1:0];
  assign idx  = acc.addr[AW+1:2];
  assign oor  = {2'b00, acc.addr[31:2]} >= 32'(DEPTH_WORDS);

  always_comb begin
    fault = oor;
    be    = 4'b0000;
    unique case (1'b1)
      acc.size == 2'b00: be = 4'b0001 << lane;
      acc.size == 2'b01: begin
        be    = 4'b0011 << lane;
        fault = fault | lane[0];
      end
      acc.size == 2'b10: begin
        be    = 4'b1111;
        fault = fault | (lane != 2'b00);
      end
      default: fault = 1'b1;
    endcase
  end

  assign word     = mem[idx];
  assign rd_sh    = word >> {lane, 3'b000};
  assign wdata_sh = acc.wdata << {lane, 3'b000};

  always_comb begin
    rdata_d = '0;
    if (!fault && !acc.we) begin
      unique case (1'b1)
        acc.size == 2'b00: rdata_d = {24'b0, rd_sh[7:0]};
        acc.size == 2'b01: rdata_d = {16'b0, rd_sh[15:0]};
        default:           rdata_d = rd_sh;
      endcase
    end
  end

  // WAIT lasts LATENCY-1 cycles: access when the count steps to 0.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    do_acc    = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          cnt_d = 4'(LATENCY - 1);
          if (LATENCY == 1) begin
            do_acc  = 1'b1;
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          do_acc  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Array is never reset; keeping its write behind the reset
  // branch means no edge during reset can commit a write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      req_q     <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && req_valid) req_q <= acc;
      if (do_acc) begin
        rsp_rdata <= rdata_d;
        rsp_err   <= fault;
        if (acc.we && !fault) begin
          for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder.
// Instance a: LATENCY=2 with backpressure; instance b: LATENCY=1 streaming.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        req_valid_b;
  logic        req_ready_b;
  logic        req_we_b;
  logic [1:0]  req_size_b;
  logic [31:0] req_addr_b;
  logic [31:0] req_wdata_b;
  logic        rsp_valid_b;
  logic        rsp_ready_b;
  logic [31:0] rsp_rdata_b;
  logic        rsp_err_b;

  int n_chk = 0;
  int n_fail = 0;

  logic        bw_we  [9];
  logic [1:0]  bw_sz  [9];
  logic [31:0] bw_ad  [9];
  logic [31:0] bw_wd  [9];
  logic [31:0] bw_exp [9];
  logic        bw_err [9];

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) u_a (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  mem_responder #(.DEPTH_WORDS(64), .LATENCY(1)) u_b (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid_b),
    .req_ready (req_ready_b),
    .req_we    (req_we_b),
    .req_size  (req_size_b),
    .req_addr  (req_addr_b),
    .req_wdata (req_wdata_b),
    .rsp_valid (rsp_valid_b),
    .rsp_ready (rsp_ready_b),
    .rsp_rdata (rsp_rdata_b),
    .rsp_err   (rsp_err_b)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Entered and left at #1 after a rising edge with the DUT in IDLE.
  task automatic xact(input string tag, input logic we,
                      input logic [1:0] sz, input logic [31:0] ad,
                      input logic [31:0] wd, input int hold,
                      input logic [31:0] exp_d, input logic exp_e);
    int n;
    req_valid = 1'b1;
    req_we    = we;
    req_size  = sz;
    req_addr  = ad;
    req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we    = ~we;
    req_size  = 2'b11;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = 32'h0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, n, 1);
    check({tag, "_d"}, rsp_rdata, exp_d);
    check({tag, "_e"}, rsp_err, exp_e);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hv"}, rsp_valid, 1'b1);
      check({tag, "_hd"}, rsp_rdata, exp_d);
      check({tag, "_he"}, rsp_err, exp_e);
      check({tag, "_hr"}, req_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, "_rdy"}, req_ready, 1'b1);
    check({tag, "_v0"}, rsp_valid, 1'b0);
  endtask

  task automatic drive_b(input int i);
    req_we_b    = bw_we[i];
    req_size_b  = bw_sz[i];
    req_addr_b  = bw_ad[i];
    req_wdata_b = bw_wd[i];
  endtask

  initial begin
    reset       = 1'b0;
    req_valid   = 1'b0;
    req_we      = 1'b0;
    req_size    = 2'b10;
    req_addr    = '0;
    req_wdata   = '0;
    rsp_ready   = 1'b0;
    req_valid_b = 1'b0;
    req_we_b    = 1'b0;
    req_size_b  = 2'b10;
    req_addr_b  = '0;
    req_wdata_b = '0;
    rsp_ready_b = 1'b1;

    bw_we  = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
    bw_sz  = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
    bw_ad  = '{32'h40, 32'h44, 32'h48, 32'h4A, 32'h40,
               32'h44, 32'h48, 32'h45, 32'h41};
    bw_wd  = '{32'h11223344, 32'h55667788, 32'hAABBCCDD, 32'h0000BEEF,
               32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    bw_exp = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h11223344,
               32'h55667788, 32'hBEEFCCDD, 32'h00000077, 32'h0};
    bw_err = '{0, 0, 0, 0, 0, 0, 0, 0, 1};

    #3;
    check("rst_rdy", req_ready, 1'b1);
    check("rst_v", rsp_valid, 1'b0);
    check("rst_d", rsp_rdata, 32'h0);
    check("rst_e", rsp_err, 1'b0);
    check("rst_b_rdy", req_ready_b, 1'b1);
    check("rst_b_v", rsp_valid_b, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    xact("w10",   1, 2'b10, 32'h10, 32'hDEADBEEF, 0, 32'h0, 0);
    xact("r10",   0, 2'b10, 32'h10, 32'h0, 0, 32'hDEADBEEF, 0);
    xact("wb12",  1, 2'b00, 32'h12, 32'hFFFFFF5A, 0, 32'h0, 0);
    xact("r10m",  0, 2'b10, 32'h10, 32'h0, 0, 32'hDE5ABEEF, 0);
    xact("rh12",  0, 2'b01, 32'h12, 32'h0, 0, 32'h0000DE5A, 0);
    xact("rb13",  0, 2'b00, 32'h13, 32'h0, 0, 32'h000000DE, 0);
    xact("rh13",  0, 2'b01, 32'h13, 32'h0, 0, 32'h0, 1);
    xact("w00",   1, 2'b10, 32'h00, 32'hCAFEF00D, 0, 32'h0, 0);
    xact("woor",  1, 2'b10, 32'h100, 32'h11111111, 0, 32'h0, 1);
    xact("r00",   0, 2'b10, 32'h00, 32'h0, 0, 32'hCAFEF00D, 0);
    xact("sz11",  0, 2'b11, 32'h10, 32'h0, 0, 32'h0, 1);
    xact("wmis",  1, 2'b10, 32'h12, 32'h0, 0, 32'h0, 1);
    xact("r10b",  0, 2'b10, 32'h10, 32'h0, 0, 32'hDE5ABEEF, 0);
    xact("w20",   1, 2'b10, 32'h20, 32'hA5A5A5A5, 0, 32'h0, 0);
    xact("bp",    0, 2'b10, 32'h10, 32'h0, 5, 32'hDE5ABEEF, 0);

    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'b10;
    req_addr  = 32'h20;
    req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("mid_rdy", req_ready, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_rdy", req_ready, 1'b1);
    check("mid_rst_v", rsp_valid, 1'b0);
    check("mid_rst_d", rsp_rdata, 32'h0);
    check("mid_rst_e", rsp_err, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    xact("r20",   0, 2'b10, 32'h20, 32'h0, 0, 32'hA5A5A5A5, 0);

    drive_b(0);
    req_valid_b = 1'b1;
    for (int i = 0; i < 9; i++) begin
      check("b_rdy", req_ready_b, 1'b1);
      @(posedge clk); #1;
      check("b_v", rsp_valid_b, 1'b1);
      check("b_d", rsp_rdata_b, bw_exp[i]);
      check("b_e", rsp_err_b, bw_err[i]);
      if (i < 8) drive_b(i + 1);
      else req_valid_b = 1'b0;
      @(posedge clk); #1;
      check("b_gap", rsp_valid_b, 1'b0);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
